// File: rtl/instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq
// Instruction fetch/dispatch sequencer. Holds the program counter, reads
// instruction words from synchronous program memory, latches them, and
// hands each one to the execution FSM with a one-cycle start pulse. It then
// waits for the execution FSM's done/pcInc handshake before advancing.
//
// Optional build macro: WDOG_EN adds a WAIT-state watchdog. If done does not
// arrive within WDOG_CYCLES WAIT cycles, the sticky fault flag is set and the
// sequencer halts. Without the macro, WAIT lasts indefinitely and fault is 0.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   memData      program memory read data (valid one cycle after memRd)
//   done         execution FSM finished the current instruction
//   pcInc        execution FSM requests PC+1 (may precede or coincide with done)
//   memAddr      program memory address (always the PC)
//   memRd        program memory read strobe
//   instruction  latched instruction word
//   start        one-cycle pulse: execution FSM should begin
//   busy         high in DISPATCH and WAIT
//   halted       high in HALT
//   fault        watchdog fault (WDOG_EN builds only)
// ---------------------------------------------------------------------------
module instr_fetch_seq #(
  parameter int         ADDR_W      = 8,
  parameter logic [3:0] HALT_OP     = 4'b1111,
  parameter int         WDOG_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       memData,
  input  logic              done,
  input  logic              pcInc,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRd,
  output logic [15:0]       instruction,
  output logic              start,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    LATCH    = 3'd1,
    DISPATCH = 3'd2,
    WAIT     = 3'd3,
    HALT     = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [15:0]       instr_reg, instr_next;
  logic              inc_flag_reg, inc_flag_next;
  // Low for the first cycle after reset release. While reset is held the
  // state sits in FETCH but memRd must read 0, so the first real FETCH
  // cycle is the one after this flag rises.
  logic              armed_reg;

`ifdef WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wdog_reg, wdog_next;
  logic          fault_reg, fault_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= FETCH;
      pc_reg       <= '0;
      instr_reg    <= 16'h0000;
      inc_flag_reg <= 1'b0;
      armed_reg    <= 1'b0;
`ifdef WDOG_EN
      wdog_reg     <= '0;
      fault_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      inc_flag_reg <= inc_flag_next;
      armed_reg    <= 1'b1;
`ifdef WDOG_EN
      wdog_reg     <= wdog_next;
      fault_reg    <= fault_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    inc_flag_next = inc_flag_reg;
`ifdef WDOG_EN
    wdog_next     = wdog_reg;
    fault_next    = fault_reg;
`endif
    case (state_reg)
      FETCH: begin
        if (armed_reg) state_next = LATCH;
      end
      LATCH: begin
        instr_next    = memData;
        inc_flag_next = 1'b0;
        state_next    = (memData[15:12] == HALT_OP) ? HALT : DISPATCH;
      end
      DISPATCH: begin
        state_next = WAIT;
`ifdef WDOG_EN
        wdog_next  = '0;
`endif
      end
      WAIT: begin
        if (done) begin
          // pcInc seen earlier in this WAIT, or alongside done, gives one +1.
          if (inc_flag_reg || pcInc) pc_next = pc_reg + ADDR_W'(1);
          state_next = FETCH;
        end else begin
          if (pcInc) inc_flag_next = 1'b1;
`ifdef WDOG_EN
          if (wdog_reg == CW'(WDOG_CYCLES - 1)) begin
            fault_next = 1'b1;
            state_next = HALT;
          end else begin
            wdog_next = wdog_reg + CW'(1);
          end
`endif
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign memAddr     = pc_reg;
  assign memRd       = (state_reg == FETCH) && armed_reg;
  assign instruction = instr_reg;
  assign start       = (state_reg == DISPATCH);
  assign busy        = (state_reg == DISPATCH) || (state_reg == WAIT);
  assign halted      = (state_reg == HALT);
`ifdef WDOG_EN
  assign fault       = fault_reg;
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_seq
// Directed bench for instr_fetch_seq. A stimulus process plays the execution
// FSM and pushes the expected fetch addresses and dispatched words into
// queues; a monitor pops and compares whenever memRd or start is presented.
// ---------------------------------------------------------------------------
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] memData;
  logic        done;
  logic        pcInc;
  logic [7:0]  memAddr;
  logic        memRd;
  logic [15:0] instruction;
  logic        start;
  logic        busy;
  logic        halted;
  logic        fault;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] mem [0:255];
  logic [7:0]  exp_fetch_q [$];
  logic [23:0] exp_start_q [$];

  always #5 clk = ~clk;

  instr_fetch_seq #(.ADDR_W(8), .HALT_OP(4'b1111), .WDOG_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .memData     (memData),
    .done        (done),
    .pcInc       (pcInc),
    .memAddr     (memAddr),
    .memRd       (memRd),
    .instruction (instruction),
    .start       (start),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault)
  );

  // Synchronous program memory: data valid the cycle after memRd.
  always @(posedge clk) begin
    if (memRd === 1'b1) memData <= mem[memAddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every fetch and every dispatch must have been predicted.
  always @(negedge clk) begin
    logic [7:0]  ef;
    logic [23:0] es;
    if (memRd === 1'b1) begin
      if (exp_fetch_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL fetch_unexpected: got memRd at addr %h expected no fetch", memAddr);
      end else begin
        ef = exp_fetch_q.pop_front();
        check("fetch_addr", {24'h0, memAddr}, {24'h0, ef});
      end
    end
    if (start === 1'b1) begin
      if (exp_start_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL start_unexpected: got start with instr %h expected no start", instruction);
      end else begin
        es = exp_start_q.pop_front();
        check("start_pc", {24'h0, memAddr}, {24'h0, es[23:16]});
        check("start_instr", {16'h0, instruction}, {16'h0, es[15:0]});
        check("busy_dispatch", {31'h0, busy}, 32'd1);
      end
    end
  end

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL start_timeout: got no start within 20 cycles expected start");
    end
  endtask

  // Called from the DISPATCH negedge; plays the execution FSM in WAIT.
  // mode 0: pcInc+done together   1: pcInc two cycles before done
  // mode 2: done without pcInc    3: repeated pcInc then done
  task automatic handshake(input int mode);
    @(posedge clk); #1;
    check("busy_wait", {31'h0, busy}, 32'd1);
    case (mode)
      0: begin
        pcInc = 1'b1; done = 1'b1;
        @(posedge clk); #1;
      end
      1: begin
        pcInc = 1'b1;
        @(posedge clk); #1; pcInc = 1'b0;
        @(posedge clk); #1; done = 1'b1;
        @(posedge clk); #1;
      end
      2: begin
        @(posedge clk); #1; done = 1'b1;
        @(posedge clk); #1;
      end
      default: begin
        pcInc = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; done = 1'b1;
        @(posedge clk); #1;
      end
    endcase
    pcInc = 1'b0; done = 1'b0;
  endtask

  task automatic do_instr(input logic [7:0] pc, input int mode);
    bit ok;
    exp_fetch_q.push_back(pc);
    exp_start_q.push_back({pc, mem[pc]});
    wait_start(ok);
    if (ok) handshake(mode);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish by 300us");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc;
    bit found;
    bit ok;

    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i) * 16'h0011;
    mem[0] = 16'h4042;
    mem[3] = 16'hF000;
    rst = 1'b0; done = 1'b0; pcInc = 1'b0; memData = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_memRd", {31'h0, memRd}, 32'd0);
    check("rst_start", {31'h0, start}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_halted", {31'h0, halted}, 32'd0);
    check("rst_fault", {31'h0, fault}, 32'd0);
    check("rst_addr", {24'h0, memAddr}, 32'd0);
    check("rst_instr", {16'h0, instruction}, 32'd0);

    // Release: fetch 0, start three clocks later
    exp_fetch_q.push_back(8'h00);
    exp_start_q.push_back({8'h00, 16'h4042});
    rst = 1'b1;
    cyc = 0; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (start === 1'b1) found = 1'b1;
    end
    check("start_latency", cyc, 32'd3);
    handshake(0);                 // PC 0 -> 1
    do_instr(8'h01, 1);           // early pcInc: 1 -> 2
    do_instr(8'h02, 2);           // no pcInc: refetch 2
    do_instr(8'h02, 3);           // multiple pcInc: single +1 -> 3

    // Halt opcode at address 3
    exp_fetch_q.push_back(8'h03);
    repeat (6) @(posedge clk);
    #1;
    check("halt_halted", {31'h0, halted}, 32'd1);
    check("halt_busy", {31'h0, busy}, 32'd0);
    check("halt_addr", {24'h0, memAddr}, 32'h03);
    check("halt_instr", {16'h0, instruction}, 32'hF000);
    check("halt_memRd", {31'h0, memRd}, 32'd0);

    // Reset out of HALT, then walk the whole address space to wrap
    rst = 1'b0; #1;
    check("rst2_halted", {31'h0, halted}, 32'd0);
    check("rst2_addr", {24'h0, memAddr}, 32'd0);
    mem[3] = 16'h3333;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 256; k++) do_instr(8'(k), 0);
    do_instr(8'h00, 0);           // wrapped FF -> 00, now 00 -> 01

    // Mid-operation reset while in WAIT
    exp_fetch_q.push_back(8'h01);
    exp_start_q.push_back({8'h01, mem[1]});
    wait_start(ok);
    @(posedge clk); #1;
    check("wait_busy_pre_rst", {31'h0, busy}, 32'd1);
    rst = 1'b0; #1;
    check("mid_rst_addr", {24'h0, memAddr}, 32'd0);
    check("mid_rst_busy", {31'h0, busy}, 32'd0);
    check("mid_rst_instr", {16'h0, instruction}, 32'd0);
    check("mid_rst_memRd", {31'h0, memRd}, 32'd0);
    done = 1'b1; pcInc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_addr", {24'h0, memAddr}, 32'd0);
    check("rst_hold_busy", {31'h0, busy}, 32'd0);
    check("rst_hold_start", {31'h0, start}, 32'd0);
    done = 1'b0; pcInc = 1'b0;
    rst = 1'b1;

    // Withhold done in WAIT
    exp_fetch_q.push_back(8'h00);
    exp_start_q.push_back({8'h00, mem[0]});
    wait_start(ok);
    repeat (20) @(posedge clk);
    #1;
`ifdef WDOG_EN
    check("wdog_fault", {31'h0, fault}, 32'd1);
    check("wdog_halted", {31'h0, halted}, 32'd1);
    check("wdog_busy", {31'h0, busy}, 32'd0);
`else
    check("wdog_fault", {31'h0, fault}, 32'd0);
    check("wdog_halted", {31'h0, halted}, 32'd0);
    check("wdog_busy", {31'h0, busy}, 32'd1);
`endif
    check("wdog_addr", {24'h0, memAddr}, 32'd0);

    check("fetch_q_empty", exp_fetch_q.size(), 32'd0);
    check("start_q_empty", exp_start_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Instruction fetch/dispatch sequencer on the control side of the MOV/ALU execution FSMs.
- Holds the program counter, reads 16-bit instruction words from synchronous program memory, and presents the latched word plus a one-cycle start pulse to the execution FSM.
- Waits for the execution FSM's done/pcInc handshake, then advances the PC and fetches the next instruction.
- It is the initiator end of the instruction/done/pcInc interface that the execution FSMs respond to.

Parameters:
- ADDR_W, 8, program-counter and memory address width.
- HALT_OP, 4'b1111, opcode in instruction[15:12] that stops sequencing.
- WDOG_CYCLES, 16, watchdog limit in WAIT cycles (used only with WDOG_EN).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset. Low clears all state immediately; release is sampled on clk.
- memData  input  16  program memory read data, valid one cycle after memRd.
- done  input  1  execution FSM finished the current instruction.
- pcInc  input  1  execution FSM requests PC+1. May arrive before or with done.
- memAddr  output  ADDR_W  program memory address, always equal to the PC.
- memRd  output  1  program memory read strobe.
- instruction  output  16  latched instruction word, stable from LATCH until the next LATCH.
- start  output  1  one-cycle pulse telling the execution FSM to begin.
- busy  output  1  high in DISPATCH and WAIT.
- halted  output  1  high in HALT.
- fault  output  1  watchdog fault flag (WDOG_EN only; tied 0 otherwise).

Behaviour:
- Reset values (rst low): PC=0, instruction=16'h0000, memRd=0, start=0, busy=0, halted=0, fault=0, incFlag=0, state=FETCH. Reset mid-instruction aborts at once; no further start is issued.
- States: FETCH, LATCH, DISPATCH, WAIT, HALT. All outputs are registered or decoded from state; none is combinational from inputs.
- FETCH: memRd=1, memAddr=PC. Always goes to LATCH next cycle.
- LATCH: instruction<=memData.
  - If memData[15:12]==HALT_OP, go to HALT.
  - Otherwise go to DISPATCH.
  - incFlag<=0.
- DISPATCH: start=1 for exactly one cycle, then WAIT.
- WAIT:
  - pcInc high in any WAIT cycle sets incFlag.
  - On the first cycle done is high, the effective increment is incFlag OR pcInc in that same cycle.
  - If the effective increment is set, PC<=PC+1 (wraps modulo 2^ADDR_W, e.g. 8'hFF to 8'h00).
  - If it is clear, PC is unchanged and the same address is refetched.
  - Then go to FETCH.
- done and pcInc are ignored outside WAIT. Multiple pcInc pulses within one WAIT still give a single +1.
- HALT: terminal state; PC frozen, halted=1. Exited only by reset.
- Latency: fetch to start is 3 cycles (FETCH, LATCH, DISPATCH). Done to the next memRd is 1 cycle.

Optional Feature:
- Macro: WDOG_EN.
- Defined: a WAIT-cycle counter is cleared on entering WAIT. If it reaches WDOG_CYCLES without done:
  - fault is set (sticky until reset);
  - the block goes to HALT with the PC unchanged.
- Undefined: no counter; WAIT lasts indefinitely; fault is tied 0.

Test Plan:
- Reset sequence: rst low then high, memData=16'h4042 → memRd at PC=0; instruction=16'h4042 after LATCH; one start pulse 3 cycles after reset release; busy=1 during DISPATCH and WAIT.
- Normal advance: pcInc and done asserted in the same WAIT cycle → PC 0→1; next memRd at address 1 one cycle later.
- Early pcInc: pcInc pulsed 2 cycles before done, pcInc low at done → PC increments exactly once. Done without any pcInc → PC stays and the same address is refetched.
- Wrap and halt: PC=8'hFF with increment → PC=8'h00. memData=16'hF000 at LATCH → halted=1, no start pulse, PC frozen.
- Mid-operation reset: rst driven low during WAIT → all outputs return to reset values asynchronously; done pulses afterwards have no effect until reset is released.
- WDOG_EN build: done withheld for 16 WAIT cycles → fault=1 and halted=1, PC unchanged. Non-WDOG_EN build: same stimulus → fault stays 0 and the block remains in WAIT.
